// File: rtl/clk_sync_filter.sv
// Multi-channel input conditioner: per-channel flop-chain synchroniser, stability-count deglitch filter,
// registered rise/fall strobes. Optional macro CLK_SYNC_FILTER_BYPASS_EN removes the filter counters.
module clk_sync_filter #(
    parameter int                DATA_W              = 1,
    parameter int                SYNC_STAGES         = 2,
    parameter int                BYPASS_SYNCHRONIZER = 0,
    parameter int                FILTER_CYCLES       = 4,
    parameter logic [DATA_W-1:0] RESET_VAL           = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] rise_pulse,
    output logic [DATA_W-1:0] fall_pulse,
    output logic              change_any
);

    logic [DATA_W-1:0] chain_out;
    logic [DATA_W-1:0] data_out_q;
    logic [DATA_W-1:0] data_out_d;
    logic [DATA_W-1:0] rise_q;
    logic [DATA_W-1:0] fall_q;
    logic              change_q;

    generate
        if (BYPASS_SYNCHRONIZER != 0) begin : g_no_sync
            // Source already lives in the clk domain.
            assign chain_out = data_in;
        end else begin : g_sync
            logic [DATA_W-1:0] sync_q [SYNC_STAGES];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= RESET_VAL;
                    end
                end else begin
                    sync_q[0] <= data_in;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= sync_q[k-1];
                    end
                end
            end

            assign chain_out = sync_q[SYNC_STAGES-1];
        end
    endgenerate

`ifdef CLK_SYNC_FILTER_BYPASS_EN
    assign data_out_d = chain_out;
`else
    localparam int CNT_W = $clog2(FILTER_CYCLES + 1);

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_chan
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             out_d;

            // Count consecutive cycles of disagreement; any agreement clears the count.
            always_comb begin
                cnt_d = '0;
                out_d = data_out_q[gi];
                if (chain_out[gi] != data_out_q[gi]) begin
                    if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) begin
                        out_d = chain_out[gi];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign data_out_d[gi] = out_d;
        end
    endgenerate
`endif

    // Strobes are derived from the same next-state that loads data_out, so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q <= RESET_VAL;
            rise_q     <= '0;
            fall_q     <= '0;
            change_q   <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            rise_q     <= data_out_d & ~data_out_q;
            fall_q     <= ~data_out_d & data_out_q;
            change_q   <= |(data_out_d ^ data_out_q);
        end
    end

    assign data_out   = data_out_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign change_any = change_q;

endmodule

// File: tb/tb_clk_sync_filter.sv
// Directed and randomized checks of clk_sync_filter against a sliding-window reference model.
module tb_clk_sync_filter;

    localparam int         DW = 4;
    localparam int         SS = 2;
    localparam int         FC = 4;
    localparam logic [3:0] RV = 4'h0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic [DW-1:0] rise_pulse;
    logic [DW-1:0] fall_pulse;
    logic          change_any;

    int checks = 0;
    int errors = 0;

    // Model: delayed view of data_in, and the last FC post-sync samples since reset.
    logic [DW-1:0] syncq[$];
    logic [DW-1:0] win[$];
    logic [DW-1:0] m_out;
    logic [DW-1:0] m_rise;
    logic [DW-1:0] m_fall;

    clk_sync_filter #(
        .DATA_W(DW),
        .SYNC_STAGES(SS),
        .BYPASS_SYNCHRONIZER(0),
        .FILTER_CYCLES(FC),
        .RESET_VAL(RV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .data_out(data_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .change_any(change_any)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // A channel flips when each of the last FC post-sync samples disagrees with its current level.
    task automatic model_edge(input logic r, input logic [DW-1:0] d);
        logic [DW-1:0] chain_v;
        logic [DW-1:0] nxt;
        bit            all_diff;
        if (r) begin
            m_out  = RV;
            m_rise = '0;
            m_fall = '0;
            syncq.delete();
            for (int k = 0; k < SS; k++) syncq.push_back(RV);
            win.delete();
        end else begin
            chain_v = syncq.pop_front();
            syncq.push_back(d);
            win.push_back(chain_v);
            if (win.size() > FC) void'(win.pop_front());
            nxt = m_out;
            for (int i = 0; i < DW; i++) begin
                all_diff = (win.size() == FC);
                foreach (win[j]) if (win[j][i] == m_out[i]) all_diff = 0;
                if (all_diff) nxt[i] = ~m_out[i];
            end
            m_rise = nxt & ~m_out;
            m_fall = ~nxt & m_out;
            m_out  = nxt;
        end
    endtask

    task automatic step(input logic r, input logic [DW-1:0] d);
        @(negedge clk);
        rst     = r;
        data_in = d;
        @(posedge clk);
        model_edge(r, d);
        #1;
        $display("t=%0t rst=%b din=%h out=%h rise=%h fall=%h chg=%b", $time, r, d,
                 data_out, rise_pulse, fall_pulse, change_any);
        chk("data_out", data_out, m_out);
        chk("rise_pulse", rise_pulse, m_rise);
        chk("fall_pulse", fall_pulse, m_fall);
        chk("change_any", {3'b000, change_any}, {3'b000, |(m_rise | m_fall)});
    endtask

    initial begin
        int            n_rise;
        int            n_chg;
        logic [DW-1:0] d;

        // Reset, then idle with zeros.
        for (int k = 0; k < 3; k++) step(1'b1, 4'h0);
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 4'h0);
            chk("idle_out", data_out, 4'h0);
            chk("idle_chg", {3'b000, change_any}, 4'h0);
        end

        // Channel 0 rises: visible at edge SS+FC only.
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 4'h1);
            chk("p2_rise", rise_pulse & 4'h1, (k == SS + FC) ? 4'h1 : 4'h0);
            chk("p2_out", data_out & 4'h1, (k >= SS + FC) ? 4'h1 : 4'h0);
        end

        // Channel 1: 3-cycle glitch is swallowed, 4-cycle pulse passes.
        for (int k = 0; k < 3; k++) step(1'b0, 4'h3);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 4'h1);
            chk("glitch_out", data_out & 4'h2, 4'h0);
        end
        for (int k = 0; k < 4; k++) step(1'b0, 4'h3);
        for (int k = 0; k < 12; k++) step(1'b0, 4'h1);
        chk("pulse_settled", data_out, 4'h1);

        // Simultaneous 0000 -> 0101.
        for (int k = 0; k < 10; k++) step(1'b0, 4'h0);
        n_rise = 0;
        n_chg  = 0;
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 4'h5);
            if (rise_pulse == 4'h5) n_rise++;
            if (change_any) n_chg++;
            chk("p4_fall", fall_pulse, 4'h0);
        end
        chk("p4_rise_count", 4'(n_rise), 4'h1);
        chk("p4_chg_count", 4'(n_chg), 4'h1);

        // Reset with the counter mid-way: full latency again after release.
        for (int k = 0; k < 10; k++) step(1'b0, 4'h0);
        for (int k = 0; k < SS + 2; k++) step(1'b0, 4'hF);
        step(1'b1, 4'hF);
        chk("p5_reset_out", data_out, RV);
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 4'hF);
            chk("p5_out", data_out, (k >= SS + FC) ? 4'hF : 4'h0);
        end

        // Randomized toggles mixing glitches and stable runs, with occasional reset.
        d = 4'hF;
        for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < DW; i++) begin
                if ($urandom_range(0, 5) == 0) d[i] = ~d[i];
            end
            step(($urandom_range(0, 99) == 0), d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_sync_filter.md
Name: clk_sync_filter

Overview:
Multi-channel input conditioner for the codec unit. It brings DATA_W asynchronous or foreign-domain signals into the clk domain through a parametrised-depth flop chain. It optionally deglitches each channel with a stability counter and emits per-channel rise/fall strobes. It is the parametrised successor of the basic synchroniser and targets codec status lines, button inputs and LRCLK/BCLK-derived flags.

Parameters:
DATA_W, 1, number of independent channels
SYNC_STAGES, 2, synchroniser flops per channel; legal 2..4
BYPASS_SYNCHRONIZER, 0, 1 = omit the sync chain so data_in feeds the filter stage directly (source already in clk domain)
FILTER_CYCLES, 4, consecutive cycles a new level must persist before data_out follows; legal 1..255
RESET_VAL, {DATA_W{1'b0}}, reset value of every sync flop and data_out

Ports:
clk  input  1  single destination clock; all logic on posedge
rst  input  1  synchronous, active-high reset
data_in  input  DATA_W  asynchronous channel inputs
data_out  output  DATA_W  synchronised, filtered levels (registered)
rise_pulse  output  DATA_W  1-cycle strobe per channel on a data_out 0->1 transition
fall_pulse  output  DATA_W  1-cycle strobe per channel on a data_out 1->0 transition
change_any  output  1  OR of rise_pulse|fall_pulse (registered, same cycle)

Behaviour:
- Reset (rst=1 at posedge):
  - sync flops and data_out load RESET_VAL.
  - Counters, rise_pulse, fall_pulse and change_any load 0.
  - Reset mid-filter discards the pending count.
  - No strobe may fire in the first cycle after reset release.
- Sync chain: s[0] <= data_in; s[k] <= s[k-1]. The chain output is s[SYNC_STAGES-1]. With BYPASS_SYNCHRONIZER=1, the chain output is data_in itself.
- Filter, per channel:
  - Counter width is clog2(FILTER_CYCLES+1).
  - If chain output == data_out: cnt <= 0.
  - Else if cnt == FILTER_CYCLES-1: data_out <= chain output and cnt <= 0.
  - Else: cnt <= cnt+1.
  - A glitch shorter than FILTER_CYCLES cycles (post-sync) never reaches data_out. Any return to the current level clears the count.
- Latency: input stable before posedge 1 reaches data_out at posedge SYNC_STAGES+FILTER_CYCLES. In bypass mode, latency is FILTER_CYCLES.
- Strobes are registered in the same posedge that updates data_out:
  - rise_pulse[i] = 1 iff data_out[i] goes 0->1 on that edge; fall_pulse[i] analogously.
  - Strobes are high exactly one cycle.
  - change_any is high in the same cycle as any strobe.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous strobes.
- Counters saturate by construction and never wrap: they always clear at FILTER_CYCLES-1.

Optional Feature:
Macro CLK_SYNC_FILTER_BYPASS_EN.
- Defined: the filter counters are removed and data_out <= chain output every cycle (equivalent to FILTER_CYCLES=1). Latency is SYNC_STAGES+1, or 1 in bypass mode. FILTER_CYCLES is ignored. Strobes are unchanged.
- Undefined: full filter as described above.

Test Plan:
1. Reset release with data_in=0, RESET_VAL=0, then hold 20 cycles -> data_out=0, no strobes, change_any=0 throughout.
2. DATA_W=1, SYNC_STAGES=2, FILTER_CYCLES=4: data_in 0->1 before edge 1 -> data_out=1 and rise_pulse=1 at edge 6 only; rise_pulse=0 at edge 7.
3. Same config: 3-cycle high glitch on data_in -> data_out stays 0, no strobe. A 4-cycle pulse -> single rise, then fall 4 cycles after return to 0.
4. DATA_W=4: data_in 4'b0000->4'b0101 same cycle -> rise_pulse=4'b0101 in one cycle, fall_pulse=0, change_any=1 for one cycle.
5. Counter at 2 of 4 when rst asserted for 1 cycle -> data_out=RESET_VAL. The count restarts, so a change needs a full SYNC_STAGES+4 edges after release.
6. BYPASS_SYNCHRONIZER=1, SYNC_STAGES=3, CLK_SYNC_FILTER_BYPASS_EN defined -> data_out follows data_in with 1-cycle latency and strobes on every toggle.
